// File: rtl/uart_baud_gen.sv
// Fractional baud-rate generator: oversample tick, bit tick and mid-bit strobe.
// The divisor is programmable at runtime, and a new value takes effect at the next period boundary.
module uart_baud_gen #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16,
  parameter int FRAC_W     = 4,
  localparam int PH_W      = $clog2(OVERSAMPLE)
) (
  input  logic              clk,
  input  logic              res_n,
  input  logic              en,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              div_load,
  input  logic              resync,
  output logic              tick_os,
  output logic              tick_baud,
  output logic              tick_mid,
  output logic [PH_W-1:0]   os_phase
);

  localparam longint DEN_L = longint'(BAUD) * longint'(OVERSAMPLE);
  localparam longint NUM_L = longint'(CLK_HZ) * (64'sd1 << FRAC_W);
  localparam longint DEF_L = (64'sd2 * NUM_L + DEN_L) / (64'sd2 * DEN_L);
  localparam logic [DIV_W-1:0]  DEF_INT  = DIV_W'(DEF_L >>> FRAC_W);
  localparam logic [FRAC_W-1:0] DEF_FRAC = FRAC_W'(DEF_L);
  localparam logic [PH_W-1:0]   PH_MID   = PH_W'(OVERSAMPLE / 2);
  localparam logic [PH_W-1:0]   PH_LAST  = PH_W'(OVERSAMPLE - 1);

  logic [DIV_W-1:0]  cnt_r;
  logic [DIV_W-1:0]  int_act_r;
  logic [DIV_W-1:0]  int_sh_r;
  logic [FRAC_W-1:0] acc_r;
  logic [FRAC_W-1:0] frac_act_r;
  logic [FRAC_W-1:0] frac_sh_r;
  logic              ext_r;
  logic              pend_r;
  logic [PH_W-1:0]   os_phase_r;
  logic              tick_os_r;
  logic              tick_baud_r;
  logic              tick_mid_r;

  logic [DIV_W-1:0]  div_eff_s;
  logic [DIV_W:0]    per_s;
  logic [DIV_W:0]    cnt_inc_s;
  logic [FRAC_W:0]   acc_sum_s;
  logic [PH_W-1:0]   phase_nx_s;
  logic              last_s;
  logic              wrap_s;

  // Period length, end-of-period detection and next accumulator/phase values
  always_comb begin
    div_eff_s = int_act_r;
    if (int_act_r == {DIV_W{1'b0}}) begin
      div_eff_s = {{(DIV_W-1){1'b0}}, 1'b1};
    end else begin
      div_eff_s = int_act_r;
    end
    per_s      = {1'b0, div_eff_s} + {{DIV_W{1'b0}}, ext_r};
    cnt_inc_s  = {1'b0, cnt_r} + {{DIV_W{1'b0}}, 1'b1};
    last_s     = (cnt_inc_s == per_s);
    wrap_s     = en & ~resync & last_s;
    acc_sum_s  = {1'b0, acc_r} + {1'b0, frac_act_r};
    phase_nx_s = os_phase_r + {{(PH_W-1){1'b0}}, 1'b1};
  end

  // Cycle counter, fractional accumulator, oversample phase and registered ticks
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      cnt_r       <= {DIV_W{1'b0}};
      acc_r       <= {FRAC_W{1'b0}};
      ext_r       <= 1'b0;
      os_phase_r  <= {PH_W{1'b0}};
      tick_os_r   <= 1'b0;
      tick_baud_r <= 1'b0;
      tick_mid_r  <= 1'b0;
    end else if (resync) begin
      cnt_r       <= {DIV_W{1'b0}};
      acc_r       <= {FRAC_W{1'b0}};
      ext_r       <= 1'b0;
      os_phase_r  <= {PH_W{1'b0}};
      tick_os_r   <= 1'b0;
      tick_baud_r <= 1'b0;
      tick_mid_r  <= 1'b0;
    end else if (en) begin
      tick_os_r   <= last_s;
      tick_baud_r <= last_s & (os_phase_r == PH_LAST);
      tick_mid_r  <= last_s & (phase_nx_s == PH_MID);
      if (last_s) begin
        cnt_r      <= {DIV_W{1'b0}};
        acc_r      <= acc_sum_s[FRAC_W-1:0];
        ext_r      <= acc_sum_s[FRAC_W];
        os_phase_r <= phase_nx_s;
      end else begin
        cnt_r      <= cnt_inc_s[DIV_W-1:0];
      end
    end else begin
      tick_os_r   <= 1'b0;
      tick_baud_r <= 1'b0;
      tick_mid_r  <= 1'b0;
    end
  end

  // Active/shadow divisor: loads while running wait for the period boundary
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      int_act_r  <= DEF_INT;
      frac_act_r <= DEF_FRAC;
      int_sh_r   <= DEF_INT;
      frac_sh_r  <= DEF_FRAC;
      pend_r     <= 1'b0;
    end else if (div_load && (!en || resync)) begin
      int_act_r  <= div_int;
      frac_act_r <= div_frac;
      pend_r     <= 1'b0;
    end else if (wrap_s) begin
      if (div_load) begin
        int_act_r  <= div_int;
        frac_act_r <= div_frac;
        pend_r     <= 1'b0;
      end else if (pend_r) begin
        int_act_r  <= int_sh_r;
        frac_act_r <= frac_sh_r;
        pend_r     <= 1'b0;
      end else begin
        pend_r     <= 1'b0;
      end
    end else if (div_load) begin
      int_sh_r  <= div_int;
      frac_sh_r <= div_frac;
      pend_r    <= 1'b1;
    end else begin
      pend_r    <= pend_r;
    end
  end

  assign tick_os   = tick_os_r;
  assign tick_baud = tick_baud_r;
  assign tick_mid  = tick_mid_r;
  assign os_phase  = os_phase_r;

endmodule
